// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - SPI command/address/data framer driving VRAM words and font bytes
// Optional VRAM read-back path is compiled in with `define SPI_CMD_READ_EN.
module spi_cmd_decoder #(
    parameter int VRAM_AW = 16,
    parameter int FONT_AW = 13
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic               spi_cs_i,
    input  logic               rx_strobe_i,
    input  logic [7:0]         rx_byte_i,
    input  logic               tx_strobe_i,
    output logic [7:0]         tx_byte_o,
    output logic               vram_req_o,
    output logic               vram_wr_o,
    output logic [VRAM_AW-1:0] vram_addr_o,
    output logic [15:0]        vram_data_o,
    input  logic               vram_ack_i,
    input  logic [15:0]        vram_data_i,
    output logic               font_wr_o,
    output logic [FONT_AW-1:0] font_addr_o,
    output logic [7:0]         font_data_o,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam logic [2:0] S_CMD    = 3'd0;
    localparam logic [2:0] S_ADDR_H = 3'd1;
    localparam logic [2:0] S_ADDR_L = 3'd2;
    localparam logic [2:0] S_DATA_H = 3'd3;
    localparam logic [2:0] S_DATA_L = 3'd4;

    logic [2:0]         state_q, state_d;
    logic               cmd_wr_q, cmd_wr_d;
    logic               cmd_font_q, cmd_font_d;
    logic [7:0]         addr_h_q, addr_h_d;
    logic [7:0]         hi_q, hi_d;
    logic               vreq_q, vreq_d;
    logic               vwr_q, vwr_d;
    logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
    logic [15:0]        vdata_q, vdata_d;
    logic               fwr_q, fwr_d;
    logic [FONT_AW-1:0] faddr_q, faddr_d;
    logic [7:0]         fdata_q, fdata_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic [7:0]         tx_q, tx_d;
`ifdef SPI_CMD_READ_EN
    logic [15:0]        rd_word_q, rd_word_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_phase_q, rd_phase_d;
`else
    logic               unused_rd_inputs;
    assign unused_rd_inputs = tx_strobe_i ^ (^vram_data_i);
`endif

    always_comb begin
        state_d    = state_q;
        cmd_wr_d   = cmd_wr_q;
        cmd_font_d = cmd_font_q;
        addr_h_d   = addr_h_q;
        hi_d       = hi_q;
        vreq_d     = vreq_q;
        vwr_d      = vwr_q;
        vaddr_d    = vaddr_q;
        vdata_d    = vdata_q;
        fwr_d      = 1'b0;
        faddr_d    = faddr_q;
        fdata_d    = fdata_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;
        tx_d       = tx_q;
`ifdef SPI_CMD_READ_EN
        rd_word_d  = rd_word_q;
        rd_valid_d = rd_valid_q;
        rd_phase_d = rd_phase_q;
`endif

        if (vreq_q && vram_ack_i) begin
            vreq_d  = 1'b0;
            vwr_d   = 1'b0;
            vaddr_d = vaddr_q + VRAM_AW'(1);
`ifdef SPI_CMD_READ_EN
            if (!vwr_q) begin
                rd_word_d  = vram_data_i;
                rd_valid_d = 1'b1;
                rd_phase_d = 1'b0;
                tx_d       = vram_data_i[15:8];
            end
`endif
        end

        if (fwr_q) begin
            faddr_d = faddr_q + FONT_AW'(1);
        end

        if (spi_cs_i) begin
            // Frame end: any half-received word in hi_q is simply never used.
            state_d = S_CMD;
            busy_d  = 1'b0;
`ifdef SPI_CMD_READ_EN
            rd_valid_d = 1'b0;
            tx_d       = 8'hFF;
`endif
        end else begin
            if (rx_strobe_i) begin
                case (state_q)
                    S_CMD: begin
                        busy_d     = 1'b1;
                        cmd_wr_d   = rx_byte_i[7];
                        cmd_font_d = rx_byte_i[6];
                        if (rx_byte_i == 8'h3F) begin
                            ovr_d = 1'b0;
                        end
                        state_d = S_ADDR_H;
                    end
                    S_ADDR_H: begin
                        addr_h_d = rx_byte_i;
                        state_d  = S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        if (cmd_font_q) begin
                            faddr_d = FONT_AW'({addr_h_q, rx_byte_i});
                        end else if (!vreq_q) begin
                            vaddr_d = VRAM_AW'({addr_h_q, rx_byte_i});
`ifdef SPI_CMD_READ_EN
                            if (!cmd_wr_q) begin
                                vreq_d = 1'b1;
                                vwr_d  = 1'b0;
                            end
`endif
                        end
`ifdef SPI_CMD_READ_EN
                        if (!cmd_wr_q && cmd_font_q) begin
                            tx_d = 8'h00;
                        end
`endif
                        state_d = S_DATA_H;
                    end
                    S_DATA_H: begin
                        hi_d = rx_byte_i;
                        if (cmd_wr_q && cmd_font_q) begin
                            fwr_d   = 1'b1;
                            fdata_d = rx_byte_i;
                        end
                        state_d = S_DATA_L;
                    end
                    default: begin
                        if (cmd_wr_q && cmd_font_q) begin
                            fwr_d   = 1'b1;
                            fdata_d = rx_byte_i;
                        end else if (cmd_wr_q) begin
                            if (vreq_q) begin
                                ovr_d = 1'b1;
                            end else begin
                                vreq_d  = 1'b1;
                                vwr_d   = 1'b1;
                                vdata_d = {hi_q, rx_byte_i};
                            end
                        end
                        state_d = S_DATA_H;
                    end
                endcase
            end
`ifdef SPI_CMD_READ_EN
            // Read-back: high byte, low byte, then fetch the next word (address already advanced on ack).
            if (tx_strobe_i && !cmd_wr_q && !cmd_font_q &&
                (state_q == S_DATA_H || state_q == S_DATA_L)) begin
                if (!rd_valid_q) begin
                    ovr_d = 1'b1;
                    tx_d  = 8'hFF;
                end else if (!rd_phase_q) begin
                    tx_d       = rd_word_q[7:0];
                    rd_phase_d = 1'b1;
                end else begin
                    rd_valid_d = 1'b0;
                    tx_d       = 8'hFF;
                    if (!vreq_q) begin
                        vreq_d = 1'b1;
                        vwr_d  = 1'b0;
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_CMD;
            cmd_wr_q   <= 1'b0;
            cmd_font_q <= 1'b0;
            addr_h_q   <= 8'h00;
            hi_q       <= 8'h00;
            vreq_q     <= 1'b0;
            vwr_q      <= 1'b0;
            vaddr_q    <= '0;
            vdata_q    <= 16'h0000;
            fwr_q      <= 1'b0;
            faddr_q    <= '0;
            fdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            tx_q       <= 8'hFF;
`ifdef SPI_CMD_READ_EN
            rd_word_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            rd_phase_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_font_q <= cmd_font_d;
            addr_h_q   <= addr_h_d;
            hi_q       <= hi_d;
            vreq_q     <= vreq_d;
            vwr_q      <= vwr_d;
            vaddr_q    <= vaddr_d;
            vdata_q    <= vdata_d;
            fwr_q      <= fwr_d;
            faddr_q    <= faddr_d;
            fdata_q    <= fdata_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            tx_q       <= tx_d;
`ifdef SPI_CMD_READ_EN
            rd_word_q  <= rd_word_d;
            rd_valid_q <= rd_valid_d;
            rd_phase_q <= rd_phase_d;
`endif
        end
    end

    assign tx_byte_o   = tx_q;
    assign vram_req_o  = vreq_q;
    assign vram_wr_o   = vwr_q;
    assign vram_addr_o = vaddr_q;
    assign vram_data_o = vdata_q;
    assign font_wr_o   = fwr_q;
    assign font_addr_o = faddr_q;
    assign font_data_o = fdata_q;
    assign busy_o      = busy_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - directed self-checking bench for spi_cmd_decoder
module tb_spi_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        spi_cs_i = 1'b1;
    logic        rx_strobe_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        tx_strobe_i = 1'b0;
    logic [7:0]  tx_byte_o;
    logic        vram_req_o;
    logic        vram_wr_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic        vram_ack_i = 1'b0;
    logic [15:0] vram_data_i = 16'h0000;
    logic        font_wr_o;
    logic [12:0] font_addr_o;
    logic [7:0]  font_data_o;
    logic        busy_o;
    logic        overrun_o;

    int checks = 0;
    int failures = 0;

    logic        ack_en = 1'b1;
    int          ack_delay = 2;
    int          wait_cnt = 0;
    logic [15:0] rd_data = 16'h0000;

    logic [32:0] vlog[$];
    logic [20:0] flog[$];

    spi_cmd_decoder #(.VRAM_AW(16), .FONT_AW(13)) dut (
        .clk(clk), .reset_n_i(reset_n_i), .spi_cs_i(spi_cs_i),
        .rx_strobe_i(rx_strobe_i), .rx_byte_i(rx_byte_i),
        .tx_strobe_i(tx_strobe_i), .tx_byte_o(tx_byte_o),
        .vram_req_o(vram_req_o), .vram_wr_o(vram_wr_o), .vram_addr_o(vram_addr_o),
        .vram_data_o(vram_data_o), .vram_ack_i(vram_ack_i), .vram_data_i(vram_data_i),
        .font_wr_o(font_wr_o), .font_addr_o(font_addr_o), .font_data_o(font_data_o),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Memory model: acknowledge a request ack_delay clocks after it is seen.
    always @(posedge clk) begin
        #1;
        if (ack_en) begin
            if (vram_ack_i) begin
                vram_ack_i = 1'b0;
            end else if (vram_req_o) begin
                if (wait_cnt >= ack_delay) begin
                    vram_ack_i  = 1'b1;
                    vram_data_i = rd_data;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (vram_req_o && vram_ack_i)
            vlog.push_back({vram_wr_o, vram_addr_o, vram_wr_o ? vram_data_o : vram_data_i});
        if (font_wr_o)
            flog.push_back({font_addr_o, font_data_o});
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte_i = b; rx_strobe_i = 1'b1;
        @(posedge clk); #1;
        rx_strobe_i = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_tx();
        @(posedge clk); #1;
        tx_strobe_i = 1'b1;
        @(posedge clk); #1;
        tx_strobe_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        @(posedge clk); #1;
        spi_cs_i = 1'b0;
    endtask

    task automatic cs_high();
        @(posedge clk); #1;
        spi_cs_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!vram_req_o) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_idle: vram_req_o stuck at %b, required 0 within 100 clks", vram_req_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_byte_o, vram_req_o, vram_wr_o, font_wr_o, busy_o, overrun_o} !== {8'hFF, 5'b0}) begin
            failures++;
            $display("FAIL reset_ctrl: tx=%h req=%b wr=%b fwr=%b busy=%b ovr=%b, required tx=ff rest 0",
                     tx_byte_o, vram_req_o, vram_wr_o, font_wr_o, busy_o, overrun_o);
        end
        checks++;
        if ({vram_addr_o, vram_data_o, font_addr_o, font_data_o} !== 53'd0) begin
            failures++;
            $display("FAIL reset_data: vaddr=%h vdata=%h faddr=%h fdata=%h, required all 0",
                     vram_addr_o, vram_data_o, font_addr_o, font_data_o);
        end
        reset_n_i = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_vram_write();
        vlog.delete(); ack_en = 1'b1; ack_delay = 2;
        cs_low();
        send_byte(8'h80);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_set: busy_o=%b, required 1", busy_o);
        end
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01);
        cs_high();
        wait_idle();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_clear: busy_o=%b, required 0", busy_o);
        end
        checks++;
        if (vlog.size() != 2 || vlog[0] !== {1'b1, 16'h1234, 16'hABCD} || vlog[1] !== {1'b1, 16'h1235, 16'hEF01}) begin
            failures++;
            $display("FAIL vram_write: %0d writes first=%h, required 2 writes 1_1234_abcd, 1_1235_ef01",
                     vlog.size(), vlog.size() > 0 ? vlog[0] : 33'h0);
        end
        checks++;
        if (vram_addr_o !== 16'h1236 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL vram_post: addr=%h ovr=%b, required addr=1236 ovr=0", vram_addr_o, overrun_o);
        end
    endtask

    task automatic test_font_wrap();
        flog.delete();
        cs_low();
        send_byte(8'hC0); send_byte(8'h1F); send_byte(8'hFF); send_byte(8'h55); send_byte(8'h66);
        cs_high();
        checks++;
        if (flog.size() != 2 || flog[0] !== {13'h1FFF, 8'h55} || flog[1] !== {13'h0000, 8'h66}) begin
            failures++;
            $display("FAIL font_wrap: %0d writes first=%h, required 1fff/55 then 0000/66",
                     flog.size(), flog.size() > 0 ? flog[0] : 21'h0);
        end
        checks++;
        if (font_addr_o !== 13'h0001 || font_wr_o !== 1'b0) begin
            failures++;
            $display("FAIL font_post: addr=%h wr=%b, required addr=0001 wr=0", font_addr_o, font_wr_o);
        end
    endtask

    task automatic test_vram_wrap();
        vlog.delete();
        cs_low();
        send_byte(8'h80); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        cs_high();
        wait_idle();
        checks++;
        if (vlog.size() != 2 || vlog[0] !== {1'b1, 16'hFFFF, 16'h1122} || vlog[1] !== {1'b1, 16'h0000, 16'h3344}) begin
            failures++;
            $display("FAIL vram_wrap: %0d writes second=%h, required ffff/1122 then 0000/3344",
                     vlog.size(), vlog.size() > 1 ? vlog[1] : 33'h0);
        end
    endtask

    task automatic test_abort();
        vlog.delete(); flog.delete();
        cs_low();
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h10); send_byte(8'hAA);
        cs_high();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy: busy_o=%b, required 0", busy_o);
        end
        cs_low();
        send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h77);
        cs_high();
        wait_idle();
        checks++;
        if (vlog.size() != 0 || flog.size() != 1 || flog[0] !== {13'h0000, 8'h77}) begin
            failures++;
            $display("FAIL abort: vram writes=%0d font writes=%0d, required 0 vram and font 0000/77",
                     vlog.size(), flog.size());
        end
    endtask

    task automatic test_overrun();
        vlog.delete(); ack_en = 1'b0;
        cs_low();
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
        #1;
        checks++;
        if (overrun_o !== 1'b1 || vram_req_o !== 1'b1 || vram_addr_o !== 16'h0040 || vram_data_o !== 16'h1111) begin
            failures++;
            $display("FAIL overrun_hold: ovr=%b req=%b addr=%h data=%h, required 1 1 0040 1111",
                     overrun_o, vram_req_o, vram_addr_o, vram_data_o);
        end
        cs_high();
        ack_en = 1'b1;
        wait_idle();
        checks++;
        if (vlog.size() != 1 || vlog[0] !== {1'b1, 16'h0040, 16'h1111} || overrun_o !== 1'b1) begin
            failures++;
            $display("FAIL overrun_single: writes=%0d ovr=%b, required 1 write 0040/1111 ovr sticky 1",
                     vlog.size(), overrun_o);
        end
        cs_low();
        send_byte(8'h3F);
        cs_high();
        checks++;
        if (overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: ovr=%b, required 0", overrun_o);
        end
    endtask

    task automatic test_stray_ack();
        ack_en = 1'b0;
        @(posedge clk); #1;
        vram_ack_i = 1'b1;
        @(posedge clk); #1;
        vram_ack_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (vram_addr_o !== 16'h0041 || vram_req_o !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack: addr=%h req=%b, required 0041 0", vram_addr_o, vram_req_o);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_read();
        vlog.delete(); rd_data = 16'hBEEF; ack_delay = 2;
        cs_low();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        repeat (6) @(posedge clk);
        #1;
`ifdef SPI_CMD_READ_EN
        checks++;
        if (vlog.size() != 1 || vlog[0] !== {1'b0, 16'h0020, 16'hBEEF} || tx_byte_o !== 8'hBE) begin
            failures++;
            $display("FAIL read_first: reads=%0d tx=%h, required read 0020 and tx=be", vlog.size(), tx_byte_o);
        end
        pulse_tx();
        checks++;
        if (tx_byte_o !== 8'hEF) begin
            failures++;
            $display("FAIL read_low: tx=%h, required ef", tx_byte_o);
        end
        ack_en = 1'b0;
        pulse_tx();
        checks++;
        if (vram_req_o !== 1'b1 || vram_wr_o !== 1'b0 || vram_addr_o !== 16'h0021) begin
            failures++;
            $display("FAIL read_next: req=%b wr=%b addr=%h, required 1 0 0021", vram_req_o, vram_wr_o, vram_addr_o);
        end
        pulse_tx();
        checks++;
        if (overrun_o !== 1'b1 || tx_byte_o !== 8'hFF) begin
            failures++;
            $display("FAIL read_early: ovr=%b tx=%h, required 1 ff", overrun_o, tx_byte_o);
        end
        ack_en = 1'b1;
        wait_idle();
        cs_high();
        cs_low();
        send_byte(8'h3F);
        cs_high();
`else
        checks++;
        if (vlog.size() != 0 || vram_req_o !== 1'b0 || tx_byte_o !== 8'hFF) begin
            failures++;
            $display("FAIL read_disabled: reads=%0d req=%b tx=%h, required 0 0 ff", vlog.size(), vram_req_o, tx_byte_o);
        end
        pulse_tx();
        cs_high();
`endif
        checks++;
        if (tx_byte_o !== 8'hFF || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL read_end: tx=%h busy=%b ovr=%b, required ff 0 0", tx_byte_o, busy_o, overrun_o);
        end
    endtask

    initial begin
        test_reset();
        test_vram_write();
        test_font_wrap();
        test_vram_wrap();
        test_abort();
        test_overrun();
        test_stray_ack();
        test_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have parameter VRAM_AW, default 16, VRAM word-address width.
REQ-002 SHALL have parameter FONT_AW, default 13, font RAM byte-address width.
REQ-003 SHALL have port clk  in  1  pixel/system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port spi_cs_i  in  1  SPI select; frame active while low.
REQ-006 SHALL have ports rx_strobe_i  in  1 and rx_byte_i  in  8, a received SPI byte valid for one clk.
REQ-007 SHALL have ports tx_strobe_i  in  1 (transmit of tx_byte_o began) and tx_byte_o  out  8 (next byte to send).
REQ-008 SHALL have ports vram_req_o  out  1, vram_wr_o  out  1, vram_addr_o  out  VRAM_AW, vram_data_o  out  16, vram_ack_i  in  1, vram_data_i  in  16 (read data valid with ack).
REQ-009 SHALL have ports font_wr_o  out  1, font_addr_o  out  FONT_AW, font_data_o  out  8.
REQ-010 SHALL have ports busy_o  out  1 (frame in progress) and overrun_o  out  1 (sticky error).

Function
REQ-011 SHALL frame as: CMD byte, ADDR_H, ADDR_L, then data bytes until spi_cs_i rises; CMD bit7 = write(1)/read(0), bit6 = target font(1)/vram(0), bits5:0 ignored.
REQ-012 SHALL use states S_CMD, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L; each rx_strobe_i advances exactly one state; S_DATA_L returns to S_DATA_H.
REQ-013 SHALL force S_CMD, drop any partial data word, and clear busy_o on spi_cs_i high, regardless of state; a pending VRAM request still completes.
REQ-014 SHALL form the address as {ADDR_H,ADDR_L} truncated to the target width.
REQ-015 VRAM write: byte in S_DATA_H latched as high byte; byte in S_DATA_L completes the word, raises vram_req_o=1, vram_wr_o=1 on the next clk.
REQ-016 SHALL hold vram_req_o, vram_wr_o, vram_addr_o, vram_data_o stable until the cycle vram_ack_i=1; request drops the following clk; the address increments by 1 on ack, wrapping 2^VRAM_AW-1 to 0.
REQ-017 SHALL set overrun_o and discard the new word if a word completes while a request is outstanding.
REQ-018 Font write: each data byte (S_DATA_H or S_DATA_L) pulses font_wr_o for one clk, one clk after rx_strobe_i, then increments the font address, wrapping 2^FONT_AW-1 to 0.
REQ-019 SHALL ignore vram_ack_i when no request is outstanding.
REQ-020 busy_o SHALL be high from the first rx_strobe_i of a frame until spi_cs_i rises.

Reset
REQ-021 On reset_n_i low, asynchronously: state S_CMD; vram_req_o, vram_wr_o, font_wr_o, busy_o, overrun_o = 0; all address/data outputs = 0; tx_byte_o = 8'hFF.
REQ-022 overrun_o SHALL clear only by reset or by a CMD byte equal to 8'h3F.

Configuration
REQ-023 Macro SPI_CMD_READ_EN SHALL compile in VRAM reads.
REQ-024 With it: after ADDR_L of a VRAM read, issue vram_req_o=1, vram_wr_o=0; on ack load word; tx_byte_o = high byte, then after tx_strobe_i low byte, then after next tx_strobe_i increment the address and issue the next read.
REQ-025 With it: a tx_strobe_i before read data arrives SHALL set overrun_o and send 8'hFF; font reads return 8'h00.
REQ-026 Without it: read commands consume bytes without memory access; tx_byte_o stays 8'hFF.

Verification
REQ-027 Write frame 80 12 34 AB CD EF 01, ack after 2 clks -> vram writes 0x1234=ABCD, 0x1235=EF01; overrun_o=0.
REQ-028 Frame C0 1F FF 55 66 -> font_wr_o pulses with addr 0x1FFF data 55, then addr 0x0000 data 66.
REQ-029 Frame 80 FF FF 11 22 33 44 -> writes 0xFFFF=1122, 0x0000=3344.
REQ-030 Frame 80 00 10 AA then spi_cs_i high, then C0 00 00 77 -> no vram write; font 0x0000=77.
REQ-031 vram_ack_i withheld, two words sent -> overrun_o=1, one write only; CMD 3F clears it.
REQ-032 SPI_CMD_READ_EN defined, frame 00 00 20, ack data BEEF -> tx_byte_o BE then EF, then read 0x0021.
